// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings and operand width.
package alu_pkg;

    localparam int ALU_W = 8;

    // 5-bit operation select; encodings 6..31 are undefined and yield zero.
    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_AND = 5'd1,
        ALU_OR  = 5'd2,
        ALU_EOR = 5'd3,
        ALU_SR  = 5'd4,
        ALU_SUB = 5'd5
    } alu_mode_t;

endpackage

// File: rtl/alu_core.sv
// Stateless ALU datapath: operands, mode and carry_in to result, C and V.
module alu_core
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [4:0]       mode,
    input  logic             carry_in,
    output logic [ALU_W-1:0] result,
    output logic             carry,
    output logic             ovf
);

    logic [ALU_W:0] sum;
    logic [ALU_W:0] diff;

    // SUB reuses the adder with b inverted, so carry_in=1 means no borrow.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b}  + {{ALU_W{1'b0}}, carry_in};
        diff = {1'b0, a} + {1'b0, ~b} + {{ALU_W{1'b0}}, carry_in};
    end

    // Per-mode result and flag selection; undefined modes fall to zero.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (mode)
            ALU_ADD: begin
                result = sum[ALU_W-1:0];
                carry  = sum[ALU_W];
                ovf    = (a[ALU_W-1] == b[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_EOR: result = a ^ b;
            ALU_SR: begin
                result = {1'b0, a[ALU_W-1:1]};
                carry  = a[0];
            end
            ALU_SUB: begin
                result = diff[ALU_W-1:0];
                carry  = diff[ALU_W];
                ovf    = (a[ALU_W-1] != b[ALU_W-1]) && (diff[ALU_W-1] != a[ALU_W-1]);
            end
            default: begin
                result = '0;
                carry  = 1'b0;
                ovf    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// 8-bit ALU with one register stage on result and N/V/Z/C candidates.
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [ALU_W-1:0] alu_a,
    input  logic [ALU_W-1:0] alu_b,
    input  logic [4:0]       mode,
    input  logic             carry_in,
    output logic [ALU_W-1:0] alu_out,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             sign
);

    logic [ALU_W-1:0] core_out;
    logic             core_c;
    logic             core_v;

    alu_core u_core (
        .a        (alu_a),
        .b        (alu_b),
        .mode     (mode),
        .carry_in (carry_in),
        .result   (core_out),
        .carry    (core_c),
        .ovf      (core_v)
    );

    // Register result and flags; reset discards the operation of that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_out   <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b1;
            sign      <= 1'b0;
        end else begin
            alu_out   <= core_out;
            carry_out <= core_c;
            overflow  <= core_v;
            zero      <= (core_out == '0);
            sign      <= core_out[ALU_W-1];
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu with hand-computed expectations.
module tb_alu;

    logic       clk;
    logic       reset;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [4:0] mode;
    logic       carry_in;
    logic [7:0] alu_out;
    logic       carry_out;
    logic       overflow;
    logic       zero;
    logic       sign;

    int n_pass;
    int n_total;

    alu dut (
        .clk       (clk),
        .reset     (reset),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .mode      (mode),
        .carry_in  (carry_in),
        .alu_out   (alu_out),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .sign      (sign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] o, input logic c,
                           input logic v, input logic z, input logic n);
        chk({tag, ".out"}, {24'd0, alu_out}, {24'd0, o});
        chk({tag, ".C"},   {31'd0, carry_out}, {31'd0, c});
        chk({tag, ".V"},   {31'd0, overflow},  {31'd0, v});
        chk({tag, ".Z"},   {31'd0, zero},      {31'd0, z});
        chk({tag, ".N"},   {31'd0, sign},      {31'd0, n});
    endtask

    // Drive on a falling edge; the result is sampled on the next falling edge.
    task automatic drive(input logic [4:0] m, input logic [7:0] a, input logic [7:0] b,
                         input logic cin);
        @(negedge clk);
        mode = m; alu_a = a; alu_b = b; carry_in = cin;
    endtask

    task automatic op(input string tag, input logic [4:0] m, input logic [7:0] a,
                      input logic [7:0] b, input logic cin, input logic [7:0] o,
                      input logic c, input logic v, input logic z, input logic n);
        drive(m, a, b, cin);
        @(negedge clk);
        chk_all(tag, o, c, v, z, n);
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b1; mode = 5'd0; alu_a = 8'h50; alu_b = 8'h50; carry_in = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 8'h00, 0, 0, 1, 0);
        reset = 1'b0;

        op("add_ovf",   5'd0, 8'h50, 8'h50, 0, 8'hA0, 0, 1, 0, 1);
        op("add_wrap",  5'd0, 8'hFF, 8'h01, 0, 8'h00, 1, 0, 1, 0);
        op("add_cin",   5'd0, 8'hFF, 8'h01, 1, 8'h01, 1, 0, 0, 0);
        op("add_neg",   5'd0, 8'h80, 8'hFF, 0, 8'h7F, 1, 1, 0, 0);
        op("sub_ovf",   5'd5, 8'h50, 8'hB0, 1, 8'hA0, 0, 1, 0, 1);
        op("sub_ok",    5'd5, 8'h05, 8'h03, 1, 8'h02, 1, 0, 0, 0);
        op("sub_brw",   5'd5, 8'h05, 8'h05, 0, 8'hFF, 0, 0, 0, 1);
        op("and",       5'd1, 8'hF0, 8'h3C, 1, 8'h30, 0, 0, 0, 0);
        op("or",        5'd2, 8'hF0, 8'h0C, 1, 8'hFC, 0, 0, 0, 1);
        op("eor",       5'd3, 8'hAA, 8'hAA, 0, 8'h00, 0, 0, 1, 0);
        op("sr",        5'd4, 8'h81, 8'h00, 0, 8'h40, 1, 0, 0, 0);
        op("sr_ign",    5'd4, 8'h02, 8'hFF, 1, 8'h01, 0, 0, 0, 0);
        op("undef7",    5'd7, 8'hFF, 8'hFF, 1, 8'h00, 0, 0, 1, 0);
        op("undef31",   5'd31, 8'h12, 8'h34, 1, 8'h00, 0, 0, 1, 0);

        // Back-to-back independence: flags of one op never leak to the next.
        drive(5'd0, 8'hFF, 8'h01, 0);
        drive(5'd1, 8'h0F, 8'h0F, 0);
        chk_all("b2b0", 8'h00, 1, 0, 1, 0);
        @(negedge clk);
        chk_all("b2b1", 8'h0F, 0, 0, 0, 0);

        // Reset mid-stream: ADD, then reset with a different op presented.
        drive(5'd0, 8'h50, 8'h50, 0);
        @(negedge clk);
        chk_all("pre_rst", 8'hA0, 0, 1, 0, 1);
        reset = 1'b1; mode = 5'd2; alu_a = 8'hF0; alu_b = 8'h0C;
        @(negedge clk);
        chk_all("mid_rst", 8'h00, 0, 0, 1, 0);
        reset = 1'b0; mode = 5'd1; alu_a = 8'hF0; alu_b = 8'h3C;
        #1;
        chk_all("rst_hold", 8'h00, 0, 0, 1, 0);
        @(negedge clk);
        chk_all("post_rst", 8'h30, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu.md
# alu

8-bit arithmetic/logic unit for the 6502-compatible `cpu` core, serving address-index arithmetic (X/Y + base, page-carry propagation) and accumulator instructions (ORA, AND, EOR, ADC, SBC, LSR). It computes one operation per cycle on two byte operands plus carry-in. The result and the N/V/Z/C flag candidates are registered once per cycle; `cpu` selects operands and mode and decides which flags to commit to P.

## Interface
- Parameters: none. Operand width is fixed at 8 bits.
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `reset`  in  1  — reset is synchronous and active-high; clears all output registers.
- `alu_a`  in  8  — operand A (accumulator, index register, BAL or ADH).
- `alu_b`  in  8  — operand B (data bus byte, constant 1, or carry value).
- `mode`  in  5  — operation select, encoded in the shared package.
- `carry_in`  in  1  — carry or borrow input.
- `alu_out`  out  8  — registered result.
- `carry_out`  out  1  — registered carry flag candidate.
- `overflow`  out  1  — registered signed-overflow flag candidate.
- `zero`  out  1  — registered result-is-zero flag.
- `sign`  out  1  — registered result bit 7.

## Operation
Mode encoding:
- ALU_ADD=0: sum = a + b + carry_in (9-bit). out=sum[7:0]; C=sum[8]; V=(a[7]==b[7]) && (out[7]!=a[7]).
- ALU_AND=1: out = a & b; C=0, V=0.
- ALU_OR=2: out = a | b; C=0, V=0.
- ALU_EOR=3: out = a ^ b; C=0, V=0.
- ALU_SR=4: logical shift right of `alu_a`; out = {1'b0, a[7:1]}; C=a[0]; V=0; `alu_b` and `carry_in` are ignored.
- ALU_SUB=5: 6502 semantics, sum = a + ~b + carry_in. carry_in=1 means no borrow. out=sum[7:0]; C=sum[8] (1 = no borrow); V=(a[7]!=b[7]) && (out[7]!=a[7]).
- Modes 6–31 (undefined): out=0x00, C=0, V=0, so Z=1, N=0.
- Z=(out==0) and N=out[7] are computed from the final 8-bit result in every mode.
- There is no decimal (BCD) mode; the D flag has no effect.

## Timing
- Fully registered. Inputs sampled on a rising edge appear on all five outputs after that edge, giving a latency of 1 cycle and a throughput of 1 operation per cycle.
- There is no handshake or valid signal; a new operation is computed every cycle.
- Reset: on a rising edge with `reset`=1, alu_out=0x00, carry_out=0, overflow=0, zero=1, sign=0.
  - Reset overrides the operation computed in that cycle.
  - An operation presented during reset is discarded, not deferred.
- Outputs hold their reset values until the first edge with `reset`=0.
- Wrap-around: ADD of 0xFF+0x01 (carry_in=0) gives 0x00 with C=1. There is no saturation in any mode.
- The combinational core has no state. Back-to-back operations are independent; flags from the previous cycle do not feed back.

## Structure
- `alu_pkg` holds:
  - the `alu_mode_t` typedef (5-bit) and the constants ALU_ADD..ALU_SUB;
  - the `ALU_W=8` width constant.
- `cpu` imports `alu_pkg` for its mode decode.
- Natural split: one combinational sub-module `alu_core` (operands, mode, carry_in → out, C, V) plus the register stage in `alu`. The Z/N flags are derived in `alu` from the core result before registering.

## Test plan
- Signed overflow on ADD: ADD 0x50+0x50, cin=0 → next cycle out=0xA0, C=0, V=1, N=1, Z=0.
- Carry and zero on ADD: ADD 0xFF+0x01, cin=0 → out=0x00, C=1, V=0, Z=1, N=0. Repeat with cin=1 → out=0x01, C=1, Z=0.
- Borrow and overflow on SUB: SUB 0x50−0xB0, cin=1 → out=0xA0, C=0, V=1, N=1. SUB 0x05−0x03, cin=1 → out=0x02, C=1, V=0.
- Logic ops and shift:
  - AND 0xF0,0x3C → 0x30.
  - OR 0xF0,0x0C → 0xFC with N=1.
  - EOR 0xAA,0xAA → 0x00 with Z=1.
  - SR a=0x81 → 0x40, C=1, N=0.
- Undefined mode: mode=7 with any operands → out=0x00, C=0, V=0, Z=1, N=0.
- Reset mid-stream: apply ADD 0x50+0x50, then assert reset on the following edge → outputs 0x00, C=0, V=0, Z=1, N=0. The first operation after deassertion appears exactly one cycle later.
